// File: rtl/compressed_line_unpacker.sv
// Parses a 128-bit compressed (or raw) line LSB-first into two codeword beats of two words each; first pair valid two cycles after line accept.
// Backpressure: pair outputs hold until i_pair_ready; no new line is taken until the second pair handshakes.
module compressed_line_unpacker #(
  parameter int LINE_WIDTH     = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int DICT_WORD      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int PTR_WIDTH      = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_line_valid,
  output logic                         o_line_ready,
  input  logic [LINE_WIDTH-1:0]        i_line,
  input  logic                         i_raw,
  output logic                         o_pair_valid,
  input  logic                         i_pair_ready,
  output logic [2:0]                   o_code1,
  output logic [2:0]                   o_code2,
  output logic [$clog2(DICT_WORD)-1:0] o_idx1,
  output logic [$clog2(DICT_WORD)-1:0] o_idx2,
  output logic [WORD_WIDTH-1:0]        o_word1,
  output logic [WORD_WIDTH-1:0]        o_word2,
  output logic                         o_last,
  output logic [PTR_WIDTH-1:0]         o_used_bits,
  output logic                         o_error
);

  localparam int IDX_W     = $clog2(DICT_WORD);
  localparam int LAST_BEAT = WORDS_PER_LINE / 2 - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DEC, ST_OUT} state_t;

  typedef struct packed {
    logic [2:0]            code;
    logic [IDX_W-1:0]      idx;
    logic [WORD_WIDTH-1:0] word;
    logic [PTR_WIDTH-1:0]  len;
    logic                  rsv;
  } dec_t;

  function automatic dec_t decode_cw(input logic [33:0] cw);
    dec_t d;
    d = '0;
    case (cw[1:0])
      2'b00: begin d.code = 3'b000; d.len = PTR_WIDTH'(2); end
      2'b01: begin d.code = 3'b001; d.word = WORD_WIDTH'(cw[33:2]); d.len = PTR_WIDTH'(34); end
      2'b10: begin d.code = 3'b010; d.idx = IDX_W'(cw[5:2]); d.len = PTR_WIDTH'(6); end
      default: begin
        case (cw[3:2])
          2'b00: begin
            d.code = 3'b011; d.idx = IDX_W'(cw[7:4]);
            d.word = WORD_WIDTH'(cw[23:8]); d.len = PTR_WIDTH'(24);
          end
          2'b01: begin d.code = 3'b100; d.word = WORD_WIDTH'(cw[11:4]); d.len = PTR_WIDTH'(12); end
          2'b10: begin
            d.code = 3'b101; d.idx = IDX_W'(cw[7:4]);
            d.word = WORD_WIDTH'(cw[15:8]); d.len = PTR_WIDTH'(16);
          end
          default: begin d.code = 3'b000; d.len = PTR_WIDTH'(4); d.rsv = 1'b1; end
        endcase
      end
    endcase
    return d;
  endfunction

  // Raw lines reuse the pointer path with fixed 32-bit literal "codewords".
  function automatic dec_t decode_any(input logic [33:0] cw, input logic raw);
    dec_t d;
    if (raw) begin
      d      = '0;
      d.code = 3'b001;
      d.word = WORD_WIDTH'(cw[31:0]);
      d.len  = PTR_WIDTH'(WORD_WIDTH);
    end else begin
      d = decode_cw(cw);
    end
    return d;
  endfunction

  state_t                state_q, state_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  raw_q, raw_d;
  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  beat_q, beat_d;
  logic                  error_q, error_d;
  logic                  line_ready_q, line_ready_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  last_q, last_d;
  logic [2:0]            code1_q, code1_d, code2_q, code2_d;
  logic [IDX_W-1:0]      idx1_q, idx1_d, idx2_q, idx2_d;
  logic [WORD_WIDTH-1:0] word1_q, word1_d, word2_q, word2_d;

  logic [33:0]           win1, win2;
  dec_t                  dec1, dec2;
  logic [PTR_WIDTH-1:0]  ptr_mid, ptr_end;
  logic                  overflow;

  // Shifting past the line end fills with zeros, so out-of-range bits read 0.
  always_comb begin
    win1     = 34'(line_q >> ptr_q);
    dec1     = decode_any(win1, raw_q);
    ptr_mid  = ptr_q + dec1.len;
    win2     = 34'(line_q >> ptr_mid);
    dec2     = decode_any(win2, raw_q);
    ptr_end  = ptr_mid + dec2.len;
    overflow = ptr_end > PTR_WIDTH'(LINE_WIDTH);
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    raw_d        = raw_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    error_d      = error_q;
    line_ready_d = line_ready_q;
    pair_valid_d = pair_valid_q;
    last_d       = last_q;
    code1_d      = code1_q;
    code2_d      = code2_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    word1_d      = word1_q;
    word2_d      = word2_q;
    case (state_q)
      ST_IDLE: begin
        if (i_line_valid && line_ready_q) begin
          line_d       = i_line;
          raw_d        = i_raw;
          ptr_d        = '0;
          beat_d       = 1'b0;
          error_d      = 1'b0;
          line_ready_d = 1'b0;
          state_d      = ST_DEC;
        end
      end
      ST_DEC: begin
        code1_d      = dec1.code;
        idx1_d       = dec1.idx;
        word1_d      = dec1.word;
        code2_d      = dec2.code;
        idx2_d       = dec2.idx;
        word2_d      = dec2.word;
        ptr_d        = ptr_end;
        last_d       = (beat_q == 1'(LAST_BEAT));
        error_d      = error_q | overflow | dec1.rsv | dec2.rsv;
        pair_valid_d = 1'b1;
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        if (i_pair_ready) begin
          pair_valid_d = 1'b0;
          if (beat_q == 1'(LAST_BEAT)) begin
            line_ready_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_DEC;
          end
        end
      end
      default: begin
        line_ready_d = 1'b1;
        pair_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      raw_q        <= 1'b0;
      ptr_q        <= '0;
      beat_q       <= 1'b0;
      error_q      <= 1'b0;
      line_ready_q <= 1'b1;
      pair_valid_q <= 1'b0;
      last_q       <= 1'b0;
      code1_q      <= '0;
      code2_q      <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      word1_q      <= '0;
      word2_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      raw_q        <= raw_d;
      ptr_q        <= ptr_d;
      beat_q       <= beat_d;
      error_q      <= error_d;
      line_ready_q <= line_ready_d;
      pair_valid_q <= pair_valid_d;
      last_q       <= last_d;
      code1_q      <= code1_d;
      code2_q      <= code2_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      word1_q      <= word1_d;
      word2_q      <= word2_d;
    end
  end

  assign o_line_ready = line_ready_q;
  assign o_pair_valid = pair_valid_q;
  assign o_code1      = code1_q;
  assign o_code2      = code2_q;
  assign o_idx1       = idx1_q;
  assign o_idx2       = idx2_q;
  assign o_word1      = word1_q;
  assign o_word2      = word2_q;
  assign o_last       = last_q;
  assign o_used_bits  = ptr_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_compressed_line_unpacker.sv
// Directed bench for compressed_line_unpacker: zero, raw, mixed, backpressure, overflow, extended codes, mid-line reset.
module tb_compressed_line_unpacker;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_line_valid;
  logic         o_line_ready;
  logic [127:0] i_line;
  logic         i_raw;
  logic         o_pair_valid;
  logic         i_pair_ready;
  logic [2:0]   o_code1, o_code2;
  logic [3:0]   o_idx1, o_idx2;
  logic [31:0]  o_word1, o_word2;
  logic         o_last;
  logic [7:0]   o_used_bits;
  logic         o_error;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  compressed_line_unpacker dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .i_line(i_line), .i_raw(i_raw),
    .o_pair_valid(o_pair_valid), .i_pair_ready(i_pair_ready),
    .o_code1(o_code1), .o_code2(o_code2),
    .o_idx1(o_idx1), .o_idx2(o_idx2),
    .o_word1(o_word1), .o_word2(o_word2),
    .o_last(o_last), .o_used_bits(o_used_bits), .o_error(o_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_line(input logic [127:0] ln, input logic raw);
    int n;
    n = 0;
    i_line = ln;
    i_raw = raw;
    i_line_valid = 1'b1;
    while (!o_line_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_in_time", 32'(n < 20), 32'd1);
    step();
    i_line_valid = 1'b0;
  endtask

  task automatic wait_pair();
    int n;
    n = 0;
    while (!o_pair_valid && n < 20) begin
      step();
      n++;
    end
    chk("pair_in_time", 32'(n < 20), 32'd1);
  endtask

  task automatic ack();
    i_pair_ready = 1'b1;
    step();
    i_pair_ready = 1'b0;
  endtask

  task automatic check_pair(input string tag,
                            input logic [31:0] c1, input logic [31:0] x1, input logic [31:0] w1,
                            input logic [31:0] c2, input logic [31:0] x2, input logic [31:0] w2,
                            input logic [31:0] last, input logic [31:0] used, input logic [31:0] err);
    chk({tag, ".valid"}, 32'(o_pair_valid), 32'd1);
    chk({tag, ".code1"}, 32'(o_code1), c1);
    chk({tag, ".idx1"},  32'(o_idx1), x1);
    chk({tag, ".word1"}, o_word1, w1);
    chk({tag, ".code2"}, 32'(o_code2), c2);
    chk({tag, ".idx2"},  32'(o_idx2), x2);
    chk({tag, ".word2"}, o_word2, w2);
    chk({tag, ".last"},  32'(o_last), last);
    chk({tag, ".used"},  32'(o_used_bits), used);
    chk({tag, ".error"}, 32'(o_error), err);
    chk({tag, ".ready"}, 32'(o_line_ready), 32'd0);
  endtask

  initial begin
    logic [127:0] ln3, ln7;
    logic [135:0] big;

    i_reset = 1'b0;
    i_line_valid = 1'b0;
    i_line = '0;
    i_raw = 1'b0;
    i_pair_ready = 1'b0;

    ln3 = '0;
    ln3[1:0] = 2'b01;
    ln3[33:2] = 32'hDEADBEEF;
    ln3[35:34] = 2'b10;
    ln3[39:36] = 4'd5;

    big = '0;
    big[33:0]    = {32'hA1A1A1A1, 2'b01};
    big[67:34]   = {32'hB2B2B2B2, 2'b01};
    big[101:68]  = {32'hC3C3C3C3, 2'b01};
    big[135:102] = {32'hD4D4D4D4, 2'b01};

    ln7 = '0;
    ln7[23:0]  = {16'hBEEF, 4'h9, 2'b00, 2'b11};
    ln7[35:24] = {8'h5A, 2'b01, 2'b11};
    ln7[51:36] = {8'hC3, 4'h7, 2'b10, 2'b11};
    ln7[55:52] = 4'b1111;

    // Reset state
    #12;
    chk("rst.valid", 32'(o_pair_valid), 32'd0);
    chk("rst.ready", 32'(o_line_ready), 32'd1);
    chk("rst.used",  32'(o_used_bits), 32'd0);
    chk("rst.word1", o_word1, 32'd0);
    i_reset = 1'b1;
    step();
    chk("post_rst.ready", 32'(o_line_ready), 32'd1);

    // All-zero compressed line, with latency checks
    send_line('0, 1'b0);
    chk("t1.dec_valid", 32'(o_pair_valid), 32'd0);
    chk("t1.dec_ready", 32'(o_line_ready), 32'd0);
    step();
    check_pair("t1p0", 0, 0, 0, 0, 0, 0, 0, 4, 0);
    ack();
    chk("t1.gap_valid", 32'(o_pair_valid), 32'd0);
    step();
    check_pair("t1p1", 0, 0, 0, 0, 0, 0, 1, 8, 0);
    ack();

    // Raw line
    send_line(128'h44444444_33333333_22222222_11111111, 1'b1);
    wait_pair();
    check_pair("t2p0", 1, 0, 32'h11111111, 1, 0, 32'h22222222, 0, 64, 0);
    ack();
    wait_pair();
    check_pair("t2p1", 1, 0, 32'h33333333, 1, 0, 32'h44444444, 1, 128, 0);
    ack();

    // Mixed xxxx + mmmm, then hold pair 0 under backpressure
    send_line(ln3, 1'b0);
    wait_pair();
    check_pair("t3p0", 1, 0, 32'hDEADBEEF, 2, 5, 0, 0, 40, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4.hold_valid", 32'(o_pair_valid), 32'd1);
      chk("t4.hold_word1", o_word1, 32'hDEADBEEF);
      chk("t4.hold_idx2",  32'(o_idx2), 32'd5);
      chk("t4.hold_used",  32'(o_used_bits), 32'd40);
    end
    ack();
    chk("t4.gap_valid", 32'(o_pair_valid), 32'd0);
    step();
    check_pair("t4p1", 0, 0, 0, 0, 0, 0, 1, 44, 0);
    ack();

    // Four literals: second pair runs past the line end
    send_line(big[127:0], 1'b0);
    wait_pair();
    check_pair("t5p0", 1, 0, 32'hA1A1A1A1, 1, 0, 32'hB2B2B2B2, 0, 68, 0);
    ack();
    wait_pair();
    check_pair("t5p1", 1, 0, 32'hC3C3C3C3, 1, 0, 32'h00D4D4D4, 1, 136, 1);
    ack();
    send_line('0, 1'b0);
    chk("t5.err_cleared", 32'(o_error), 32'd0);
    wait_pair();
    check_pair("t5n0", 0, 0, 0, 0, 0, 0, 0, 4, 0);
    ack();
    wait_pair();
    ack();

    // Extended sub-codes including the reserved one
    send_line(ln7, 1'b0);
    wait_pair();
    check_pair("t7p0", 3, 9, 32'h0000BEEF, 4, 0, 32'h5A, 0, 36, 0);
    ack();
    wait_pair();
    check_pair("t7p1", 5, 7, 32'hC3, 0, 0, 0, 1, 56, 1);
    ack();

    // Reset during pair 0 output
    send_line(ln3, 1'b0);
    wait_pair();
    i_reset = 1'b0;
    #1;
    chk("t6.valid", 32'(o_pair_valid), 32'd0);
    chk("t6.code1", 32'(o_code1), 32'd0);
    chk("t6.word1", o_word1, 32'd0);
    chk("t6.idx2",  32'(o_idx2), 32'd0);
    chk("t6.used",  32'(o_used_bits), 32'd0);
    chk("t6.ready", 32'(o_line_ready), 32'd1);
    #3;
    i_reset = 1'b1;
    step();
    chk("t6.post_ready", 32'(o_line_ready), 32'd1);
    chk("t6.post_valid", 32'(o_pair_valid), 32'd0);
    send_line(ln3, 1'b0);
    wait_pair();
    check_pair("t6p0", 1, 0, 32'hDEADBEEF, 2, 5, 0, 0, 40, 0);
    ack();
    wait_pair();
    check_pair("t6p1", 0, 0, 0, 0, 0, 0, 1, 44, 0);
    ack();
    step();
    chk("end.ready", 32'(o_line_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
